// File: rtl/ft2232h_pkg.sv
// Shared encodings for the FT2232H command-frame parser: FSM states, error codes
// and the default frame preamble.
package ft2232h_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] PREAMBLE_DEFAULT = 8'hAA;

    function automatic logic in_frame(input state_t s);
        return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/ft2232h_frame_buf.sv
// Payload holding buffer: MAX_LEN x 8 register array with independent write and
// read pointers; read data is a mux off the registered read pointer.
module ft2232h_frame_buf
    import ft2232h_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int PTR_W  = $clog2(MAX_LEN) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_adv_i,
    output logic [7:0]       rd_data_o,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] rptr_o
);

    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]       mem [MAX_LEN];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_adv_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign rd_data_o = mem[rptr_q[AW-1:0]];
    assign wptr_o    = wptr_q;
    assign rptr_o    = rptr_q;

endmodule

// File: rtl/ft2232h_cmd_parser.sv
// FT2232H command-frame parser: delimits PREAMBLE/CMD/LEN/payload/CHK frames and
// streams checksum-verified payloads. Optional inter-byte timeout: FT2232H_CMD_TIMEOUT_EN.
//
// state   | meaning
// HUNT    | waiting for PREAMBLE, other bytes ignored
// CMD     | next byte is the command
// LEN     | next byte is the payload length
// PAYLOAD | collecting LEN payload bytes into the buffer
// CHK     | next byte is the XOR checksum
// EMIT    | streaming the verified payload; incoming bytes dropped
module ft2232h_cmd_parser
    import ft2232h_pkg::*;
#(
    parameter logic [7:0] PREAMBLE       = PREAMBLE_DEFAULT,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       hdr_valid_o,
    output logic [7:0] cmd_o,
    output logic [7:0] len_o,
    output logic       data_valid_o,
    output logic [7:0] data_o,
    output logic       data_last_o,
    input  logic       data_ready_i,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic       drop_o
);

    localparam int         PTR_W     = $clog2(MAX_LEN) + 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, len_q, csum_q;
    logic [7:0]       cmd_out_q, len_out_q;
    logic             hdr_valid_q, err_q;
    logic [1:0]       err_code_q, err_code_d;
    logic             err_set, hdr_set, wr_en, rd_adv, buf_clr;
    logic             timeout_hit;
    logic             emit_valid, last_beat;
    logic [PTR_W-1:0] wptr, rptr;
    logic [7:0]       rd_data;

    ft2232h_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (buf_clr),
        .wr_en_i   (wr_en),
        .wr_data_i (byte_i),
        .rd_adv_i  (rd_adv),
        .rd_data_o (rd_data),
        .wptr_o    (wptr),
        .rptr_o    (rptr)
    );

    // The hdr_valid cycle is already EMIT but carries no beat yet.
    assign emit_valid = (state_q == ST_EMIT) && !hdr_valid_q;
    assign last_beat  = (8'(rptr) == (len_q - 8'd1));

`ifdef FT2232H_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (byte_valid_i) begin
            timer_q <= TW'(TIMEOUT_CYCLES - 1);
        end else if (in_frame(state_q) && (timer_q != '0)) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    assign timeout_hit = in_frame(state_q) && !byte_valid_i && (timer_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_set    = 1'b0;
        err_code_d = ERR_NONE;
        hdr_set    = 1'b0;
        wr_en      = 1'b0;
        rd_adv     = 1'b0;
        buf_clr    = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (byte_valid_i && (byte_i == PREAMBLE)) begin
                    state_d = ST_CMD;
                    buf_clr = 1'b1;
                end
            end
            ST_CMD: begin
                if (byte_valid_i) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_valid_i) begin
                    if (byte_i > MAX_LEN_B) begin
                        state_d    = ST_HUNT;
                        err_set    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (byte_i == 8'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid_i) begin
                    wr_en = 1'b1;
                    if ((8'(wptr) + 8'd1) == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (byte_valid_i) begin
                    if (byte_i == csum_q) begin
                        hdr_set = 1'b1;
                        state_d = (len_q == 8'd0) ? ST_HUNT : ST_EMIT;
                    end else begin
                        state_d    = ST_HUNT;
                        err_set    = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                end
            end
            ST_EMIT: begin
                if (emit_valid && data_ready_i) begin
                    rd_adv = 1'b1;
                    if (last_beat) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
        if (timeout_hit) begin
            state_d    = ST_HUNT;
            err_set    = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            cmd_out_q   <= '0;
            len_out_q   <= '0;
            hdr_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            hdr_valid_q <= hdr_set;
            err_q       <= err_set;
            if (err_set) begin
                err_code_q <= err_code_d;
            end
            if (hdr_set) begin
                cmd_out_q <= cmd_q;
                len_out_q <= len_q;
            end
            if (byte_valid_i) begin
                case (state_q)
                    ST_CMD: begin
                        cmd_q  <= byte_i;
                        csum_q <= byte_i;
                    end
                    ST_LEN: begin
                        len_q  <= byte_i;
                        csum_q <= csum_q ^ byte_i;
                    end
                    ST_PAYLOAD: csum_q <= csum_q ^ byte_i;
                    default: ;
                endcase
            end
        end
    end

    assign busy_o       = (state_q == ST_EMIT);
    assign hdr_valid_o  = hdr_valid_q;
    assign cmd_o        = cmd_out_q;
    assign len_o        = len_out_q;
    assign data_valid_o = emit_valid;
    assign data_o       = emit_valid ? rd_data : 8'h00;
    assign data_last_o  = emit_valid && last_beat;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign drop_o       = (state_q == ST_EMIT) && byte_valid_i;

endmodule

// File: tb/tb_ft2232h_cmd_parser.sv
// Directed self-checking bench for ft2232h_cmd_parser; the timeout scenario follows
// FT2232H_CMD_TIMEOUT_EN.
module tb_ft2232h_cmd_parser;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       byte_valid_i = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic       data_ready_i = 1'b1;
    logic       busy_o, hdr_valid_o, data_valid_o, data_last_o, err_o, drop_o;
    logic [7:0] cmd_o, len_o, data_o;
    logic [1:0] err_code_o;

    int n_checks = 0;
    int n_fail   = 0;

    int         hdr_cnt, err_cnt, drop_cnt, busy_cnt, stall_viol, n_beats;
    logic [7:0] beats [16];
    logic       lasts [16];
    logic       prev_stall;
    logic [7:0] prev_data;

    ft2232h_cmd_parser dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .busy_o       (busy_o),
        .hdr_valid_o  (hdr_valid_o),
        .cmd_o        (cmd_o),
        .len_o        (len_o),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .data_last_o  (data_last_o),
        .data_ready_i (data_ready_i),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .drop_o       (drop_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (hdr_valid_o) hdr_cnt <= hdr_cnt + 1;
            if (err_o) err_cnt <= err_cnt + 1;
            if (drop_o) drop_cnt <= drop_cnt + 1;
            if (busy_o) busy_cnt <= busy_cnt + 1;
            if (data_valid_o && data_ready_i && n_beats < 16) begin
                beats[n_beats] <= data_o;
                lasts[n_beats] <= data_last_o;
                n_beats <= n_beats + 1;
            end
            if (prev_stall && (!data_valid_o || data_o !== prev_data))
                stall_viol <= stall_viol + 1;
            prev_stall <= data_valid_o && !data_ready_i;
            prev_data  <= data_o;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task clear_mon();
        hdr_cnt = 0; err_cnt = 0; drop_cnt = 0; busy_cnt = 0;
        stall_viol = 0; n_beats = 0;
    endtask

    task send(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_i = b;
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0;
    endtask

    task idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task test_reset();
        rst_i = 1'b1;
        idle(3);
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0 || hdr_valid_o !== 1'b0 || data_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: busy=%b hdr=%b dv=%b expected 0 0 0", busy_o, hdr_valid_o, data_valid_o); end
        n_checks++; if (cmd_o !== 8'h00 || len_o !== 8'h00 || data_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: cmd=%h len=%h data=%h expected 00 00 00", cmd_o, len_o, data_o); end
        n_checks++; if (err_o !== 1'b0 || err_code_o !== 2'b00 || drop_o !== 1'b0 || data_last_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: err=%b code=%b drop=%b last=%b expected all 0", err_o, err_code_o, drop_o, data_last_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        idle(1);
    endtask

    task test_single();
        clear_mon();
        data_ready_i = 1'b1;
        send(8'hAA); send(8'h01); send(8'h01); send(8'h5A); send(8'h5A);
        @(negedge clk_i);
        n_checks++; if (hdr_valid_o !== 1'b1 || data_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL single_hdr_lat: hdr=%b dv=%b expected 1 0", hdr_valid_o, data_valid_o); end
        n_checks++; if (cmd_o !== 8'h01 || len_o !== 8'h01) begin
            n_fail++; $display("FAIL single_hdr: cmd=%h len=%h expected 01 01", cmd_o, len_o); end
        @(negedge clk_i);
        n_checks++; if (data_valid_o !== 1'b1 || data_o !== 8'h5A || data_last_o !== 1'b1) begin
            n_fail++; $display("FAIL single_beat_lat: dv=%b data=%h last=%b expected 1 5a 1", data_valid_o, data_o, data_last_o); end
        idle(3);
        n_checks++; if (n_beats !== 1 || beats[0] !== 8'h5A || lasts[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_beats: n=%0d b0=%h last0=%b expected 1 5a 1", n_beats, beats[0], lasts[0]); end
        n_checks++; if (hdr_cnt !== 1 || err_cnt !== 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_counts: hdr=%0d err=%0d busy=%b expected 1 0 0", hdr_cnt, err_cnt, busy_o); end
    endtask

    task test_zero_len();
        clear_mon();
        send(8'hAA); send(8'h10); send(8'h00); send(8'h10);
        idle(3);
        n_checks++; if (hdr_cnt !== 1 || cmd_o !== 8'h10 || len_o !== 8'h00) begin
            n_fail++; $display("FAIL zero_len_hdr: hdr=%0d cmd=%h len=%h expected 1 10 00", hdr_cnt, cmd_o, len_o); end
        n_checks++; if (n_beats !== 0 || busy_cnt !== 0 || err_cnt !== 0) begin
            n_fail++; $display("FAIL zero_len_idle: beats=%0d busy=%0d err=%0d expected 0 0 0", n_beats, busy_cnt, err_cnt); end
    endtask

    task test_bad_chk();
        clear_mon();
        send(8'hAA); send(8'h02); send(8'h02); send(8'h11); send(8'h22); send(8'h00);
        idle(3);
        n_checks++; if (err_cnt !== 1 || err_code_o !== 2'b01 || hdr_cnt !== 0) begin
            n_fail++; $display("FAIL bad_chk_err: err=%0d code=%b hdr=%0d expected 1 01 0", err_cnt, err_code_o, hdr_cnt); end
        n_checks++; if (cmd_o !== 8'h10 || len_o !== 8'h00 || n_beats !== 0) begin
            n_fail++; $display("FAIL bad_chk_hold: cmd=%h len=%h beats=%0d expected 10 00 0", cmd_o, len_o, n_beats); end
    endtask

    task test_len_err();
        clear_mon();
        send(8'hAA); send(8'h03); send(8'h11);
        idle(2);
        n_checks++; if (err_cnt !== 1 || err_code_o !== 2'b10 || hdr_cnt !== 0) begin
            n_fail++; $display("FAIL len_err: err=%0d code=%b hdr=%0d expected 1 10 0", err_cnt, err_code_o, hdr_cnt); end
        clear_mon();
        send(8'hAA); send(8'h01); send(8'h01); send(8'hAA); send(8'hAA);
        idle(4);
        n_checks++; if (hdr_cnt !== 1 || cmd_o !== 8'h01 || len_o !== 8'h01 || err_cnt !== 0) begin
            n_fail++; $display("FAIL len_err_recover: hdr=%0d cmd=%h len=%h err=%0d expected 1 01 01 0", hdr_cnt, cmd_o, len_o, err_cnt); end
        n_checks++; if (n_beats !== 1 || beats[0] !== 8'hAA || lasts[0] !== 1'b1) begin
            n_fail++; $display("FAIL preamble_payload: n=%0d b0=%h last=%b expected 1 aa 1", n_beats, beats[0], lasts[0]); end
    endtask

    task test_stall();
        logic [3:0] pat;
        pat = 4'b1001;
        clear_mon();
        data_ready_i = 1'b1;
        send(8'hAA); send(8'h05); send(8'h04);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h45);
        for (int i = 0; i < 14; i++) begin
            data_ready_i = pat[i % 4];
            byte_valid_i = (i == 1 || i == 3 || i == 5);
            byte_i = 8'hAA;
            @(posedge clk_i); #1;
        end
        byte_valid_i = 1'b0;
        data_ready_i = 1'b1;
        idle(2);
        n_checks++; if (n_beats !== 4 || beats[0] !== 8'h11 || beats[1] !== 8'h22 || beats[2] !== 8'h33 || beats[3] !== 8'h44) begin
            n_fail++; $display("FAIL stall_order: n=%0d %h %h %h %h expected 4 11 22 33 44", n_beats, beats[0], beats[1], beats[2], beats[3]); end
        n_checks++; if ({lasts[0], lasts[1], lasts[2], lasts[3]} !== 4'b0001) begin
            n_fail++; $display("FAIL stall_last: %b%b%b%b expected 0001", lasts[0], lasts[1], lasts[2], lasts[3]); end
        n_checks++; if (stall_viol !== 0 || drop_cnt !== 3) begin
            n_fail++; $display("FAIL stall_hold_drop: viol=%0d drops=%0d expected 0 3", stall_viol, drop_cnt); end
        n_checks++; if (busy_o !== 1'b0 || hdr_cnt !== 1 || err_cnt !== 0) begin
            n_fail++; $display("FAIL stall_end: busy=%b hdr=%0d err=%0d expected 0 1 0", busy_o, hdr_cnt, err_cnt); end
    endtask

    task test_back_to_back();
        clear_mon();
        send(8'h55); send(8'h00);
        send(8'hAA); send(8'h10); send(8'h00); send(8'h10);
        send(8'hAA); send(8'h20); send(8'h00); send(8'h20);
        idle(3);
        n_checks++; if (hdr_cnt !== 2 || cmd_o !== 8'h20 || err_cnt !== 0 || busy_cnt !== 0) begin
            n_fail++; $display("FAIL back_to_back: hdr=%0d cmd=%h err=%0d busy=%0d expected 2 20 0 0", hdr_cnt, cmd_o, err_cnt, busy_cnt); end
    endtask

    task test_timeout();
        clear_mon();
        send(8'hAA); send(8'h01);
`ifdef FT2232H_CMD_TIMEOUT_EN
        begin
            int  cnt;
            logic found;
            cnt = 0;
            found = 1'b0;
            while (!found && cnt < 5000) begin
                @(negedge clk_i);
                cnt++;
                if (err_o) found = 1'b1;
            end
            n_checks++; if (found !== 1'b1 || cnt !== 4097) begin
                n_fail++; $display("FAIL timeout_cycles: found=%b cycle=%0d expected 1 4097", found, cnt); end
            n_checks++; if (err_code_o !== 2'b11 || hdr_cnt !== 0) begin
                n_fail++; $display("FAIL timeout_code: code=%b hdr=%0d expected 11 0", err_code_o, hdr_cnt); end
            @(posedge clk_i); #1;
            idle(2);
        end
`else
        idle(300);
        n_checks++; if (err_cnt !== 0) begin
            n_fail++; $display("FAIL no_timeout: err=%0d expected 0", err_cnt); end
        send(8'h00); send(8'h01);
        idle(3);
        n_checks++; if (hdr_cnt !== 1 || cmd_o !== 8'h01 || len_o !== 8'h00) begin
            n_fail++; $display("FAIL late_frame: hdr=%0d cmd=%h len=%h expected 1 01 00", hdr_cnt, cmd_o, len_o); end
`endif
    endtask

    task test_reset_mid();
        clear_mon();
        send(8'hAA); send(8'h01); send(8'h04); send(8'h11); send(8'h22);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0 || err_o !== 1'b0 || hdr_valid_o !== 1'b0 || data_valid_o !== 1'b0 || drop_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctl: busy=%b err=%b hdr=%b dv=%b drop=%b expected all 0", busy_o, err_o, hdr_valid_o, data_valid_o, drop_o); end
        n_checks++; if (cmd_o !== 8'h00 || len_o !== 8'h00 || err_code_o !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_regs: cmd=%h len=%h code=%b expected 00 00 00", cmd_o, len_o, err_code_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        send(8'h33); send(8'h44); send(8'h00);
        idle(3);
        n_checks++; if (err_cnt !== 0 || hdr_cnt !== 0 || n_beats !== 0) begin
            n_fail++; $display("FAIL rst_mid_after: err=%0d hdr=%0d beats=%0d expected 0 0 0", err_cnt, hdr_cnt, n_beats); end
    endtask

    initial begin
        clear_mon();
        @(posedge clk_i); #1;
        test_reset();
        test_single();
        test_zero_len();
        test_bad_chk();
        test_len_err();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
